// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb
// Architectural register file with a write-back commit port, two
// combinational decode read ports and per-register pending-write
// scoreboard counters used to stall decode on RAW hazards.
//
// Optional feature macro: WB_REGFILE_BYPASS_EN
//   defined   : write-back data is forwarded to the read ports in the
//               commit cycle, and the stall is dropped when that commit
//               retires the last pending write.
//   undefined : reads return stored state only; the stall drops the
//               cycle after the final write-back.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   wb_en         write-back commit strobe
//   wb_addr       write-back destination register
//   wb_data       write-back result
//   rd_addr_a/b   decode source register indices
//   rd_data_a/b   decode source operands (combinational)
//   stall_a/b     source operand not yet available
//   iss_valid     decode issues an instruction writing iss_rd
//   iss_rd        destination reserved by the issuing instruction
//   iss_ready     reservation can be accepted this cycle
//   err_underflow sticky flag: write-back with no pending reservation
module wb_regfile_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              stall_a,
    output logic              stall_b,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    output logic              err_underflow
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Per-register state gathered into read-only views for the read ports.
    logic [DATA_W-1:0] data_q [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];

    logic wb_nz;
    logic wb_dec_ok;
    logic iss_fire;
    logic err_reg;

    assign wb_nz     = wb_en && (wb_addr != '0);
    // A write-back only retires a reservation if one is outstanding.
    assign wb_dec_ok = wb_nz && (cnt_q[wb_addr] != '0);

    // A full counter can still take a new reservation when the same cycle
    // retires one of its writes, so the net count does not overflow.
    assign iss_ready = !((iss_rd != '0) && (cnt_q[iss_rd] == CNT_MAX) &&
                         !(wb_dec_ok && (wb_addr == iss_rd)));
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : gen_reg
            if (gi == 0) begin : gen_zero
                // Register 0 is hardwired to zero and never reserved.
                assign data_q[gi] = '0;
                assign cnt_q[gi]  = '0;
            end else begin : gen_live
                localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
                logic [DATA_W-1:0] data_reg;
                logic [CNT_W-1:0]  cnt_reg;
                logic              inc;
                logic              dec;

                assign inc = iss_fire && (iss_rd == IDX);
                assign dec = wb_en && (wb_addr == IDX) && (cnt_reg != '0);

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        data_reg <= '0;
                        cnt_reg  <= '0;
                    end else begin
                        if (wb_en && (wb_addr == IDX)) begin
                            data_reg <= wb_data;
                        end
                        if (inc && !dec) begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end else if (dec && !inc) begin
                            cnt_reg <= cnt_reg - CNT_ONE;
                        end
                    end
                end

                assign data_q[gi] = data_reg;
                assign cnt_q[gi]  = cnt_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else if (wb_nz && (cnt_q[wb_addr] == '0)) begin
            err_reg <= 1'b1;
        end
    end

    assign err_underflow = err_reg;

    // Read ports. Stall uses the counter value before this cycle's update,
    // so an instruction reserving its own source still sees the old state.
`ifdef WB_REGFILE_BYPASS_EN
    logic hit_a;
    logic hit_b;

    assign hit_a     = wb_nz && (wb_addr == rd_addr_a);
    assign hit_b     = wb_nz && (wb_addr == rd_addr_b);
    assign rd_data_a = hit_a ? wb_data : data_q[rd_addr_a];
    assign rd_data_b = hit_b ? wb_data : data_q[rd_addr_b];
    // The stall lifts only if this commit retires the last pending write.
    assign stall_a   = (cnt_q[rd_addr_a] != '0) &&
                       !(hit_a && (cnt_q[rd_addr_a] == CNT_ONE));
    assign stall_b   = (cnt_q[rd_addr_b] != '0) &&
                       !(hit_b && (cnt_q[rd_addr_b] == CNT_ONE));
`else
    assign rd_data_a = data_q[rd_addr_a];
    assign rd_data_b = data_q[rd_addr_b];
    assign stall_a   = (cnt_q[rd_addr_a] != '0);
    assign stall_b   = (cnt_q[rd_addr_b] != '0);
`endif

endmodule
